// File: rtl/robber_lang_arbiter.sv
// Round-robin arbiter sharing one robber_language core between two byte-stream requesters.
// Optional per-requester accepted-byte counters are enabled with ROBBER_ARB_STATS_EN.
module robber_lang_arbiter #(
  parameter int unsigned QUANTUM      = 8,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset_l,
  input  logic [7:0] req0_data,
  input  logic       req0_valid,
  input  logic       req0_encdec,
  output logic       req0_ready,
  input  logic [7:0] req1_data,
  input  logic       req1_valid,
  input  logic       req1_encdec,
  output logic       req1_ready,
  output logic [7:0] rsp0_data,
  output logic       rsp0_valid,
  output logic [7:0] rsp1_data,
  output logic       rsp1_valid,
  output logic       core_init,
  output logic       core_encdec,
  output logic [7:0] core_data_in,
  output logic       core_data_in_valid,
  input  logic [7:0] core_data_out,
  input  logic       core_data_out_valid,
`ifdef ROBBER_ARB_STATS_EN
  output logic [15:0] stat0_bytes,
  output logic [15:0] stat1_bytes,
`endif
  output logic       owner,
  output logic       owner_active
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StInit   = 3'd1;
  localparam logic [2:0] StSettle = 3'd2;
  localparam logic [2:0] StRun    = 3'd3;
  localparam logic [2:0] StGap    = 3'd4;
  localparam logic [2:0] StDrain  = 3'd5;

  localparam logic [7:0] QuantumW  = 8'(QUANTUM);
  localparam logic [7:0] DrainInit = 8'(DRAIN_CYCLES - 1);

  logic [2:0] state_q, state_d;
  logic       owner_q, owner_d;
  logic       active_q, active_d;
  logic       last_owner_q, last_owner_d;
  logic       mode_q, mode_d;
  logic [7:0] count_q, count_d;
  logic       switch_pending_q, switch_pending_d;
  logic       gap_q, gap_d;
  logic [7:0] drain_q, drain_d;

  logic       own_valid, own_encdec, oth_valid;
  logic [7:0] own_data;
  logic       run_ready, hs;

  function automatic logic is_consonant(input logic [7:0] b);
    case (b)
      "a", "e", "i", "o", "u", "y",
      "A", "E", "I", "O", "U", "Y": is_consonant = 1'b0;
      default:                      is_consonant = 1'b1;
    endcase
  endfunction

  always_comb begin
    own_valid  = owner_q ? req1_valid  : req0_valid;
    own_encdec = owner_q ? req1_encdec : req0_encdec;
    own_data   = owner_q ? req1_data   : req0_data;
    oth_valid  = owner_q ? req0_valid  : req1_valid;
    // Ready is deliberately independent of the valid inputs.
    run_ready  = (state_q == StRun) & ~switch_pending_q & (own_encdec == mode_q);
    hs         = run_ready & own_valid;
  end

  assign req0_ready         = run_ready & ~owner_q;
  assign req1_ready         = run_ready & owner_q;
  assign core_data_in_valid = hs;
  assign core_data_in       = hs ? own_data : 8'h00;
  assign core_init          = (state_q == StInit);
  assign core_encdec        = mode_q;
  assign owner              = owner_q;
  assign owner_active       = active_q;

  assign rsp0_valid = core_data_out_valid & active_q & ~owner_q;
  assign rsp1_valid = core_data_out_valid & active_q & owner_q;
  // Data is zeroed when not valid so every output reads 0 while reset is held.
  assign rsp0_data  = rsp0_valid ? core_data_out : 8'h00;
  assign rsp1_data  = rsp1_valid ? core_data_out : 8'h00;

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    active_d         = active_q;
    last_owner_d     = last_owner_q;
    mode_d           = mode_q;
    count_d          = count_q;
    switch_pending_d = switch_pending_q;
    gap_d            = gap_q;
    drain_d          = drain_q;
    unique case (state_q)
      StIdle: begin
        if (req0_valid | req1_valid) begin
          owner_d  = (req0_valid & req1_valid) ? ~last_owner_q : req1_valid;
          active_d = 1'b1;
          mode_d   = owner_d ? req1_encdec : req0_encdec;
          count_d  = 8'd0;
          state_d  = StInit;
        end
      end
      StInit:   state_d = StSettle;
      StSettle: state_d = StRun;
      StRun: begin
        if (switch_pending_q) begin
          state_d          = StDrain;
          switch_pending_d = 1'b0;
          drain_d          = DrainInit;
        end else begin
          if (hs) begin
            count_d = (count_q == QuantumW) ? count_q : count_q + 8'd1;
            if (mode_q & is_consonant(own_data)) begin
              state_d = StGap;
              gap_d   = 1'b1;
            end
          end
          // Post-increment count so the quantum-ending byte is the last one accepted.
          if ((oth_valid & ((count_d == QuantumW) | ~own_valid)) |
              (own_valid & (own_encdec != mode_q))) begin
            switch_pending_d = 1'b1;
          end
        end
      end
      StGap: begin
        if (gap_q) gap_d = 1'b0;
        else       state_d = StRun;
      end
      StDrain: begin
        if (drain_q == 8'd0) begin
          state_d      = StIdle;
          last_owner_d = owner_q;
          active_d     = 1'b0;
        end else begin
          drain_d = drain_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q          <= StIdle;
      owner_q          <= 1'b0;
      active_q         <= 1'b0;
      last_owner_q     <= 1'b1;
      mode_q           <= 1'b0;
      count_q          <= 8'd0;
      switch_pending_q <= 1'b0;
      gap_q            <= 1'b0;
      drain_q          <= 8'd0;
    end else begin
      state_q          <= state_d;
      owner_q          <= owner_d;
      active_q         <= active_d;
      last_owner_q     <= last_owner_d;
      mode_q           <= mode_d;
      count_q          <= count_d;
      switch_pending_q <= switch_pending_d;
      gap_q            <= gap_d;
      drain_q          <= drain_d;
    end
  end

`ifdef ROBBER_ARB_STATS_EN
  logic [15:0] stat0_q, stat1_q;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      stat0_q <= 16'd0;
      stat1_q <= 16'd0;
    end else begin
      if (hs & ~owner_q & (stat0_q != 16'hFFFF)) stat0_q <= stat0_q + 16'd1;
      if (hs & owner_q & (stat1_q != 16'hFFFF))  stat1_q <= stat1_q + 16'd1;
    end
  end

  assign stat0_bytes = stat0_q;
  assign stat1_bytes = stat1_q;
`endif

endmodule

// File: tb/tb_robber_lang_arbiter.sv
// Directed bench for robber_lang_arbiter with a behavioural robber_language core model.
// Also checks the stat counters when built with ROBBER_ARB_STATS_EN.
module tb_robber_lang_arbiter;

  logic       clk = 1'b0;
  logic       reset_l = 1'b0;
  logic [7:0] req0_data = 8'h0, req1_data = 8'h0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_encdec = 1'b0, req1_encdec = 1'b0;
  logic       req0_ready, req1_ready;
  logic [7:0] rsp0_data, rsp1_data;
  logic       rsp0_valid, rsp1_valid;
  logic       core_init, core_encdec, core_data_in_valid;
  logic [7:0] core_data_in;
  logic [7:0] core_data_out = 8'h0;
  logic       core_data_out_valid = 1'b0;
  logic       owner, owner_active;
`ifdef ROBBER_ARB_STATS_EN
  logic [15:0] stat0_bytes, stat1_bytes;
`endif

  robber_lang_arbiter #(.QUANTUM(8), .DRAIN_CYCLES(3)) dut (
    .clk                 (clk),
    .reset_l             (reset_l),
    .req0_data           (req0_data),
    .req0_valid          (req0_valid),
    .req0_encdec         (req0_encdec),
    .req0_ready          (req0_ready),
    .req1_data           (req1_data),
    .req1_valid          (req1_valid),
    .req1_encdec         (req1_encdec),
    .req1_ready          (req1_ready),
    .rsp0_data           (rsp0_data),
    .rsp0_valid          (rsp0_valid),
    .rsp1_data           (rsp1_data),
    .rsp1_valid          (rsp1_valid),
    .core_init           (core_init),
    .core_encdec         (core_encdec),
    .core_data_in        (core_data_in),
    .core_data_in_valid  (core_data_in_valid),
    .core_data_out       (core_data_out),
    .core_data_out_valid (core_data_out_valid),
`ifdef ROBBER_ARB_STATS_EN
    .stat0_bytes         (stat0_bytes),
    .stat1_bytes         (stat1_bytes),
`endif
    .owner               (owner),
    .owner_active        (owner_active)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] q0[$], q1[$];
  logic       en0 = 1'b0, en1 = 1'b0, enc0 = 1'b0, enc1 = 1'b0;
  logic       hs0, hs1, s_init, s_enc, s_cdiv;
  logic [7:0] s_cdi;
  logic [7:0] pend[$];
  int         skip = 0;
  logic [7:0] r0_log[$], r1_log[$];
  int         r0_cyc[$], r1_cyc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic is_cons(input logic [7:0] b);
    logic [7:0] l;
    l = (b >= 8'h41 && b <= 8'h5A) ? b + 8'h20 : b;
    return !(l inside {8'h61, 8'h65, 8'h69, 8'h6F, 8'h75, 8'h79});
  endfunction

  task automatic drive_inputs();
    req0_valid  = en0 && (q0.size() > 0);
    req0_data   = req0_valid ? q0[0] : 8'h00;
    req0_encdec = enc0;
    req1_valid  = en1 && (q1.size() > 0);
    req1_data   = req1_valid ? q1[0] : 8'h00;
    req1_encdec = enc1;
  endtask

  task automatic sample();
    hs0    = req0_valid & req0_ready;
    hs1    = req1_valid & req1_ready;
    s_init = core_init;
    s_enc  = core_encdec;
    s_cdiv = core_data_in_valid;
    s_cdi  = core_data_in;
    if (rsp0_valid) begin r0_log.push_back(rsp0_data); r0_cyc.push_back(cyc); end
    if (rsp1_valid) begin r1_log.push_back(rsp1_data); r1_cyc.push_back(cyc); end
  endtask

  // Core model: one output byte the cycle after input; encode consonant adds 'o' and repeat,
  // decode consonant swallows the next two input bytes.
  task automatic core_update();
    logic       v;
    logic [7:0] d;
    v = 1'b0;
    d = 8'h00;
    if (s_init) begin pend.delete(); skip = 0; end
    if (s_cdiv) begin
      if (s_enc) begin
        v = 1'b1; d = s_cdi;
        if (is_cons(s_cdi)) begin pend.push_back(8'h6F); pend.push_back(s_cdi); end
      end else if (skip > 0) begin
        skip--;
      end else begin
        v = 1'b1; d = s_cdi;
        if (is_cons(s_cdi)) skip = 2;
      end
    end else if (pend.size() > 0) begin
      v = 1'b1; d = pend.pop_front();
    end
    core_data_out_valid = v;
    core_data_out       = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    core_update();
    if (hs0) void'(q0.pop_front());
    if (hs1) void'(q1.pop_front());
    drive_inputs();
    cyc++;
    @(negedge clk);
    sample();
  endtask

  task automatic step_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic reset_dut();
    reset_l = 1'b0;
    pend.delete(); skip = 0;
    core_data_out = 8'h00; core_data_out_valid = 1'b0;
    r0_log.delete(); r0_cyc.delete(); r1_log.delete(); r1_cyc.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_l = 1'b1;
    cyc = 0;
    drive_inputs();
    @(negedge clk);
    sample();
  endtask

  task automatic load0(input string s);
    q0.delete();
    for (int i = 0; i < s.len(); i++) q0.push_back(s[i]);
  endtask

  task automatic load1(input string s);
    q1.delete();
    for (int i = 0; i < s.len(); i++) q1.push_back(s[i]);
  endtask

  initial begin
    // Test 1: single encode consonant
    load0("b"); q1.delete(); en0 = 1; enc0 = 1; en1 = 0; enc1 = 0;
    reset_dut();
    check("t1_reset_active", owner_active, 0);
    check("t1_reset_owner", owner, 0);
    check("t1_init_c0", core_init, 0);
    step(); check("t1_init_c1", core_init, 1);
    check("t1_encdec_c1", core_encdec, 1);
    step(); check("t1_ready_c2", req0_ready, 0);
    check("t1_init_c2", core_init, 0);
    step(); check("t1_ready_c3", req0_ready, 1);
    check("t1_cdiv_c3", core_data_in_valid, 1);
    check("t1_cdi_c3", core_data_in, "b");
    step(); check("t1_ready_c4", req0_ready, 0);
    check("t1_rsp_c4", {rsp0_valid, rsp0_data}, {1'b1, 8'h62});
    step(); check("t1_ready_c5", req0_ready, 0);
    check("t1_rsp_c5", {rsp0_valid, rsp0_data}, {1'b1, 8'h6F});
    step(); check("t1_ready_c6", req0_ready, 1);
    check("t1_rsp_c6", {rsp0_valid, rsp0_data}, {1'b1, 8'h62});
    step(); check("t1_rsp_c7", rsp0_valid, 0);

    // Test 2: encode stream "ab"
    load0("ab"); en0 = 1; enc0 = 1;
    reset_dut();
    step_to(3); check("t2_cdi_c3", {core_data_in_valid, core_data_in}, {1'b1, 8'h61});
    step(); check("t2_cdi_c4", {core_data_in_valid, core_data_in}, {1'b1, 8'h62});
    step_to(9);
    check("t2_rsp0_n", r0_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] exp_b[4];
      exp_b = '{8'h61, 8'h62, 8'h6F, 8'h62};
      check($sformatf("t2_rsp0_b%0d", i), i < r0_log.size() ? r0_log[i] : 8'hxx, exp_b[i]);
      check($sformatf("t2_rsp0_c%0d", i), i < r0_cyc.size() ? r0_cyc[i] : -1, 4 + i);
    end
    check("t2_rsp1_n", r1_log.size(), 0);

    // Test 3: contention; req0 encode vowels yields after quantum, req1 decodes "bob"x4
    load0("aeiouyaeio"); load1("bobbobbobbob");
    en0 = 1; enc0 = 1; en1 = 1; enc1 = 0;
    reset_dut();
    check("t3_first_owner_c1", owner, 0);
    step_to(10); check("t3_ready0_c10", req0_ready, 1);
    step(); check("t3_ready0_c11", req0_ready, 0);
    check("t3_ready1_c11", req1_ready, 0);
    step(); check("t3_active_c12", owner_active, 1);
    step_to(14); check("t3_active_c14", owner_active, 1);
    check("t3_init_c14", core_init, 0);
    step(); check("t3_active_c15", owner_active, 0);
    check("t3_init_c15", core_init, 0);
    step(); check("t3_init_c16", core_init, 1);
    check("t3_encdec_c16", core_encdec, 0);
    check("t3_owner_c16", owner, 1);
    en0 = 0;
    step_to(18); check("t3_ready1_c18", req1_ready, 1);
    step_to(31);
    check("t3_rsp0_n", r0_log.size(), 8);
    check("t3_rsp0_last", r0_log.size() > 0 ? r0_log[r0_log.size() - 1] : 8'hxx, "e");
    check("t3_rsp1_n", r1_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_rsp1_b%0d", i), i < r1_log.size() ? r1_log[i] : 8'hxx, "b");
      check($sformatf("t3_rsp1_c%0d", i), i < r1_cyc.size() ? r1_cyc[i] : -1, 19 + 3 * i);
    end
    check("t3_q1_drained", q1.size(), 0);
`ifdef ROBBER_ARB_STATS_EN
    check("t6_stat0", stat0_bytes, 8);
    check("t6_stat1", stat1_bytes, 12);
`endif

    // Test 4: owner flips encode->decode while valid
    load0("aei"); q1.delete(); en0 = 1; enc0 = 1; en1 = 0;
    reset_dut();
    step_to(4); check("t4_cdi_c4", {core_data_in_valid, core_data_in}, {1'b1, 8'h65});
    enc0 = 0;
    step(); check("t4_ready_c5", req0_ready, 0);
    step(); check("t4_ready_c6", req0_ready, 0);
    step(); check("t4_active_c7", owner_active, 1);
    step_to(10); check("t4_active_c10", owner_active, 0);
    step(); check("t4_init_c11", core_init, 1);
    check("t4_encdec_c11", core_encdec, 0);
    step_to(13); check("t4_cdi_c13", {req0_ready, core_data_in_valid, core_data_in},
                       {1'b1, 1'b1, 8'h69});
    step(); check("t4_rsp_c14", {rsp0_valid, rsp0_data}, {1'b1, 8'h69});

    // Test 5: asynchronous reset during GAP
    load0("b"); en0 = 1; enc0 = 1;
    reset_dut();
    step_to(4);
    check("t5_gap_rsp", rsp0_valid, 1);
    reset_l = 1'b0;
    #1;
    check("t5_async_outs",
          {req0_ready, req1_ready, rsp0_valid, rsp1_valid, core_init, core_encdec,
           core_data_in_valid, owner, owner_active},
          9'b0);
    check("t5_async_data", {rsp0_data, rsp1_data, core_data_in}, 24'h0);
    q0.delete(); en0 = 0;
    reset_dut();
    check("t5_active_c0", owner_active, 0);
    step(); check("t5_init_c1", core_init, 0);
    step_to(3); check("t5_ready_c3", req0_ready, 0);
    check("t5_no_rsp", r0_log.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
